// File: rtl/pe_writeback_controller.sv
// Sixteen-lane PE result writeback: registers each accepted lane result and
// steers it to its output bank with a per-bank saturating write address.
module pe_writeback_controller #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13,
    parameter int LIMIT  = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic [15:0]           valid,
    input  logic [16*DATA_W-1:0]  data_in,
    output logic [15:0]           wr_en,
    output logic [16*DATA_W-1:0]  wr_data,
    output logic [ADDR_W-1:0]     addr_1,
    output logic [ADDR_W-1:0]     addr_2,
    output logic [ADDR_W-1:0]     addr_3,
    output logic [ADDR_W-1:0]     addr_4,
    output logic [ADDR_W-1:0]     addr_5,
    output logic [ADDR_W-1:0]     addr_6,
    output logic [ADDR_W-1:0]     addr_7,
    output logic [ADDR_W-1:0]     addr_8,
    output logic [ADDR_W-1:0]     addr_9,
    output logic [ADDR_W-1:0]     addr_10,
    output logic [ADDR_W-1:0]     addr_11,
    output logic [ADDR_W-1:0]     addr_12,
    output logic [ADDR_W-1:0]     addr_13,
    output logic [ADDR_W-1:0]     addr_14,
    output logic [ADDR_W-1:0]     addr_15,
    output logic [ADDR_W-1:0]     addr_16,
    output logic                  busy,
    output logic                  done,
    output logic                  drop_err
);

    // One extra bit so a counter can hold LIMIT == 2^ADDR_W without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q  [16];
    logic [CNT_W-1:0]      cnt_d  [16];
    logic [ADDR_W-1:0]     addr_q [16];
    logic [ADDR_W-1:0]     addr_d [16];
    logic [15:0]           wr_en_q, wr_en_d;
    logic [16*DATA_W-1:0]  wr_data_q, wr_data_d;
    logic                  drop_err_q, drop_err_d;
    logic [15:0]           full, accept;
    logic                  drop_any;
    logic                  all_full_d;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            full[i]   = (cnt_q[i] == LIMIT_C);
            accept[i] = valid[i] & en & (state_q == RUN) & ~full[i] & ~clear;
        end
        // Any presented result that is not taken outside IDLE is lost.
        drop_any = (|(valid & ~accept)) & (state_q != IDLE) & ~clear;
    end

    always_comb begin
        wr_en_d    = accept;
        wr_data_d  = wr_data_q;
        drop_err_d = drop_err_q;
        all_full_d = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cnt_d[i]  = cnt_q[i];
            addr_d[i] = addr_q[i];
            if (clear || state_q == IDLE) begin
                cnt_d[i] = '0;
            end else if (accept[i]) begin
                cnt_d[i]  = cnt_q[i] + ONE_C;
                addr_d[i] = cnt_q[i][ADDR_W-1:0];
                wr_data_d[DATA_W*i +: DATA_W] = data_in[DATA_W*i +: DATA_W];
            end
            if (cnt_d[i] != LIMIT_C) begin
                all_full_d = 1'b0;
            end
        end
        if (clear) begin
            drop_err_d = 1'b0;
        end else if (drop_any) begin
            drop_err_d = 1'b1;
        end
    end

    // DONE is entered on the post-accept counts so it coincides with the last write.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (en) state_d = RUN;
                RUN: begin
                    if (all_full_d)  state_d = DONE;
                    else if (!en)    state_d = PAUSE;
                end
                PAUSE:   if (en) state_d = RUN;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
            drop_err_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                cnt_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            drop_err_q <= drop_err_d;
            for (int i = 0; i < 16; i++) begin
                cnt_q[i]  <= cnt_d[i];
                addr_q[i] <= addr_d[i];
            end
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign drop_err = drop_err_q;
    assign busy     = (state_q == RUN) || (state_q == PAUSE);
    assign done     = (state_q == DONE);

    assign addr_1  = addr_q[0];
    assign addr_2  = addr_q[1];
    assign addr_3  = addr_q[2];
    assign addr_4  = addr_q[3];
    assign addr_5  = addr_q[4];
    assign addr_6  = addr_q[5];
    assign addr_7  = addr_q[6];
    assign addr_8  = addr_q[7];
    assign addr_9  = addr_q[8];
    assign addr_10 = addr_q[9];
    assign addr_11 = addr_q[10];
    assign addr_12 = addr_q[11];
    assign addr_13 = addr_q[12];
    assign addr_14 = addr_q[13];
    assign addr_15 = addr_q[14];
    assign addr_16 = addr_q[15];

endmodule
